pipeline_stall_ctrl: RTL

- Central responder to pipeline hazard requests in the 5-stage CPU.
- Consumes stall, flush, memory-wait and halt requests from:
  - the load→branch/jr hazard detector,
  - the general load-use detector,
  - ID-stage branch/jump resolution,
  - the data memory.
- Drives the write-enable, flush and bubble controls of the PC and every pipeline buffer.
- Tracks long stalls with a watchdog and keeps saturating performance counters.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 65 ++++++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall units of the 5-stage core:
// controller states, opcode constants, default widths and the RUN-cycle decision.
package pipeline_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2,
        ST_ERROR    = 2'd3
    } ctrl_state_t;

    localparam int unsigned DEF_CNT_W   = 16;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned DEF_TO_W    = 7;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_BNE   = 7'b1100111;
    localparam logic [6:0] OP_J     = 7'b1101111;
    localparam logic [6:0] OP_JAL   = 7'b1101011;
    localparam logic [6:0] OP_JR    = 7'b1110011;
    localparam logic [6:0] OP_HLT   = 7'b1111111;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic mux_sel;
        logic id_ex_write;
        logic ex_mem_write;
        logic mem_wb_write;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                      mux_sel: 1'b0, id_ex_write: 1'b1, ex_mem_write: 1'b1,
                                      mem_wb_write: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '0;
    localparam ctrl_t CTRL_PARKED = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                      mux_sel: 1'b1, id_ex_write: 1'b0, ex_mem_write: 1'b0,
                                      mem_wb_write: 1'b0};

    // Priority: halt > memory wait > load hazard > redirect; a stall masks the flush
    // because the branch operand is not yet resolved.
    function automatic ctrl_t run_eval(input logic hlt, input logic busy,
                                       input logic stall, input logic redirect);
        ctrl_t c;
        c = CTRL_RUN;
        if (hlt) begin
            c = CTRL_PARKED;
        end else if (busy) begin
            c = CTRL_FREEZE;
        end else if (stall) begin
            c.pc_write    = 1'b0;
            c.if_id_write = 1'b0;
            c.mux_sel     = 1'b1;
        end else if (redirect) begin
            c.if_id_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: combinational pipeline controls, a registered
// state machine with memory-wait watchdog, and saturating performance counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TO_W    = DEF_TO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             lu_stall,
    input  logic             branch_taken,
    input  logic             jump_taken,
    input  logic             mem_busy,
    input  logic             ex_hlt,
    output logic             PC_Write,
    output logic             if_id_Write,
    output logic             if_id_flush,
    output logic             id_ex_cntrl_mux_sel,
    output logic             id_ex_Write,
    output logic             ex_mem_Write,
    output logic             mem_wb_Write,
    output logic             halted,
    output logic             wdt_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [TO_W:0] TO_LIMIT = (TO_W+1)'(TIMEOUT);

    ctrl_state_t   state;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W:0]   wait_nxt;
    ctrl_t         ctrl;
    logic          active;
    logic          stall_req;
    logic          redirect_req;

    assign stall_req    = hz_stall | lu_stall;
    assign redirect_req = branch_taken | jump_taken;
    assign active       = (state == ST_RUN) || (state == ST_MEM_WAIT);
    assign wait_nxt     = {1'b0, wait_cnt} + (TO_W+1)'(1);

    always_comb begin
        ctrl = CTRL_PARKED;
        case (state)
            ST_RUN:      ctrl = run_eval(ex_hlt, mem_busy, stall_req, redirect_req);
            ST_MEM_WAIT: ctrl = mem_busy ? CTRL_FREEZE
                                         : run_eval(ex_hlt, 1'b0, stall_req, redirect_req);
            default:     ctrl = CTRL_PARKED;
        endcase
    end

    assign PC_Write            = ctrl.pc_write;
    assign if_id_Write         = ctrl.if_id_write;
    assign if_id_flush         = ctrl.if_id_flush;
    assign id_ex_cntrl_mux_sel = ctrl.mux_sel;
    assign id_ex_Write         = ctrl.id_ex_write;
    assign ex_mem_Write        = ctrl.ex_mem_write;
    assign mem_wb_Write        = ctrl.mem_wb_write;

    // RUN and the release cycle of MEM_WAIT share one path; only a still-busy
    // memory in MEM_WAIT masks a halt request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            halted   <= 1'b0;
            wdt_err  <= 1'b0;
        end else begin
            case (state)
                ST_RUN, ST_MEM_WAIT: begin
                    if ((state == ST_MEM_WAIT) && mem_busy) begin
                        wait_cnt <= wait_nxt[TO_W-1:0];
                        if (wait_nxt >= TO_LIMIT) begin
                            state   <= ST_ERROR;
                            wdt_err <= 1'b1;
                        end
                    end else if (ex_hlt) begin
                        state    <= ST_HALTED;
                        halted   <= 1'b1;
                        wait_cnt <= '0;
                    end else if (mem_busy) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (active && !ctrl.pc_write),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (active && ctrl.if_id_flush),
        .q   (flush_cnt)
    );

endmodule
